wb_mem_arbiter: RTL and testbench

WB_MEM_ARBITER -- requirements
Module: wb_mem_arbiter

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_rr_pick2.sv | 18 +
 rtl/wb_mem_arbiter.sv | 149 ++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_pkg : shared types and constants for the Wishbone bus blocks    |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
package wb_pkg;

    localparam int WB_TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } wb_arb_state_e;

endpackage
`default_nettype wire

// File: rtl/wb_rr_pick2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_rr_pick2 : two-way round-robin pick from a request pair         |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module wb_rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       idx_o
);

    // On a tie the master that was not served last wins.
    assign valid_o = |req_i;
    assign idx_o   = (&req_i) ? ~last_grant_i : req_i[1];

endmodule
`default_nettype wire

// File: rtl/wb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | wb_mem_arbiter : 2-master Wishbone arbiter with slave-ack timeout  |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module wb_mem_arbiter
    import wb_pkg::*;
#(
    parameter int TIMEOUT = WB_TIMEOUT_DEFAULT,
    parameter int AW      = 32
) (
    input  logic          wb_clk,
    input  logic          wb_rst,

    input  logic          m0_cyc_i,
    input  logic          m0_stb_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [AW-1:0] m0_dat_i,
    output logic          m0_ack_o,
    output logic          m0_err_o,
    output logic [AW-1:0] m0_dat_o,

    input  logic          m1_cyc_i,
    input  logic          m1_stb_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [AW-1:0] m1_dat_i,
    output logic          m1_ack_o,
    output logic          m1_err_o,
    output logic [AW-1:0] m1_dat_o,

    output logic          s_cyc_o,
    output logic          s_stb_o,
    output logic          s_we_o,
    output logic [AW-1:0] s_addr_o,
    output logic [AW-1:0] s_dat_o,
    input  logic          s_ack_i,
    input  logic [AW-1:0] s_dat_i
);

    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    wb_arb_state_e state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    err_block_q, err_block_d;

    logic [1:0]    cyc_w;
    logic [1:0]    req_w;
    logic          pick_valid_w;
    logic          pick_idx_w;
    logic          own_valid_w;
    logic          own_w;
    logic          sel_cyc_w;
    logic          sel_stb_w;
    logic          sel_we_w;
    logic [AW-1:0] sel_addr_w;
    logic [AW-1:0] sel_dat_w;
    logic          timeout_w;

    assign cyc_w = {m1_cyc_i, m0_cyc_i};
    assign req_w = cyc_w & ~err_block_q;

    wb_rr_pick2 u_pick (
        .req_i        (req_w),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid_w),
        .idx_o        (pick_idx_w)
    );

    // Reset gates the grant combinationally so an aborted transfer never leaks an ack.
    assign own_valid_w = (state_q != ST_IDLE) && !wb_rst;
    assign own_w       = (state_q == ST_GRANT1);

    assign sel_cyc_w  = own_w ? m1_cyc_i  : m0_cyc_i;
    assign sel_stb_w  = own_w ? m1_stb_i  : m0_stb_i;
    assign sel_we_w   = own_w ? m1_we_i   : m0_we_i;
    assign sel_addr_w = own_w ? m1_addr_i : m0_addr_i;
    assign sel_dat_w  = own_w ? m1_dat_i  : m0_dat_i;

    assign timeout_w = own_valid_w && sel_cyc_w && (cnt_q == TMAX) && !s_ack_i;

    assign s_cyc_o  = own_valid_w && sel_cyc_w && !timeout_w;
    assign s_stb_o  = own_valid_w && sel_stb_w && !timeout_w;
    assign s_we_o   = own_valid_w && sel_we_w;
    assign s_addr_o = own_valid_w ? sel_addr_w : '0;
    assign s_dat_o  = own_valid_w ? sel_dat_w  : '0;

    assign m0_ack_o = own_valid_w && !own_w && s_ack_i;
    assign m1_ack_o = own_valid_w &&  own_w && s_ack_i;
    assign m0_err_o = timeout_w && !own_w;
    assign m1_err_o = timeout_w &&  own_w;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        err_block_d  = err_block_q & cyc_w;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (pick_valid_w) begin
                    state_d = pick_idx_w ? ST_GRANT1 : ST_GRANT0;
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (timeout_w) begin
                    state_d             = ST_IDLE;
                    last_grant_d        = own_w;
                    err_block_d[own_w]  = 1'b1;
                    cnt_d               = '0;
                end else if (!sel_cyc_w) begin
                    last_grant_d = own_w;
                    cnt_d        = '0;
                    if (own_w ? req_w[0] : req_w[1]) begin
                        state_d = own_w ? ST_GRANT0 : ST_GRANT1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (s_ack_i) begin
                    cnt_d = '0;
                end else if (s_stb_o && (cnt_q != TMAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            err_block_q  <= 2'b00;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            err_block_q  <= err_block_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_mem_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_wb_mem_arbiter : self-checking bench for wb_mem_arbiter         |
// | Rev 1.0 : initial release                                          |
// +--------------------------------------------------------------------+
module tb_wb_mem_arbiter;

    localparam int TO = 16;

    logic        wb_clk = 1'b0;
    logic        wb_rst = 1'b1;
    logic        m0_cyc = 1'b0, m0_stb = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_dat = '0;
    logic        m1_cyc = 1'b0, m1_stb = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_dat = '0;
    logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [31:0] s_addr_o, s_dat_o;
    logic        s_ack_i;
    logic [31:0] s_dat_i;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 wb_clk = ~wb_clk;

    wb_mem_arbiter #(.TIMEOUT(TO), .AW(32)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_addr_i(m0_addr), .m0_dat_i(m0_dat),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_addr_o(s_addr_o), .s_dat_o(s_dat_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
    );

    // Data memory: one-cycle registered ack, optional stall and random wait states.
    logic [31:0] mem [0:63];
    logic        ack_q = 1'b0;
    logic [31:0] rdat_q = '0;
    logic        stall = 1'b0, force_ack = 1'b0, rand_ack = 1'b0;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[4] = 32'hDEADBEEF;
    end

    always @(posedge wb_clk) begin
        if (s_cyc_o && s_stb_o && !ack_q && !stall &&
            (!rand_ack || $urandom_range(0, 2) != 0)) begin
            ack_q  <= 1'b1;
            rdat_q <= mem[s_addr_o[7:2]];
            if (s_we_o) mem[s_addr_o[7:2]] <= s_dat_o;
        end else begin
            ack_q <= 1'b0;
        end
    end

    assign s_ack_i = force_ack | ack_q;
    assign s_dat_i = rdat_q;

    // Reference model: who owns the bus, who was served last, how long the owner has waited.
    typedef struct {
        int       owner;
        int       last;
        int       timer;
        bit [1:0] blk;
    } mdl_t;

    mdl_t mdl = '{owner: -1, last: 1, timer: 0, blk: 2'b00};

    function automatic mdl_t mdl_next(mdl_t m);
        mdl_t n = m;
        bit   c[2], s[2], rq[2];
        int   o;
        c[0] = m0_cyc; c[1] = m1_cyc;
        s[0] = m0_stb; s[1] = m1_stb;
        if (wb_rst) begin
            n.owner = -1; n.last = 1; n.timer = 0; n.blk = 2'b00;
            return n;
        end
        for (int i = 0; i < 2; i++) begin
            rq[i]    = c[i] && !m.blk[i];
            n.blk[i] = m.blk[i] && c[i];
        end
        o = m.owner;
        if (o < 0) begin
            n.timer = 0;
            if (rq[0] && rq[1]) n.owner = 1 - m.last;
            else if (rq[0])     n.owner = 0;
            else if (rq[1])     n.owner = 1;
        end else if (c[o] && m.timer == TO && !s_ack_i) begin
            n.owner = -1; n.last = o; n.blk[o] = 1'b1; n.timer = 0;
        end else if (!c[o]) begin
            n.last  = o;
            n.owner = rq[1-o] ? 1 - o : -1;
            n.timer = 0;
        end else if (s_ack_i) begin
            n.timer = 0;
        end else if (s[o] && m.timer < TO) begin
            n.timer = m.timer + 1;
        end
        return n;
    endfunction

    always @(posedge wb_clk) mdl <= mdl_next(mdl);

    function automatic logic [70:0] expect_outs();
        logic        v, c, s, w, t;
        logic [31:0] a, d;
        v = !wb_rst && mdl.owner >= 0;
        c = (mdl.owner == 1) ? m1_cyc  : m0_cyc;
        s = (mdl.owner == 1) ? m1_stb  : m0_stb;
        w = (mdl.owner == 1) ? m1_we   : m0_we;
        a = (mdl.owner == 1) ? m1_addr : m0_addr;
        d = (mdl.owner == 1) ? m1_dat  : m0_dat;
        t = v && c && mdl.timer == TO && !s_ack_i;
        return {v && c && !t, v && s && !t, v && w, v ? a : 32'h0, v ? d : 32'h0,
                v && mdl.owner == 0 && s_ack_i, t && mdl.owner == 0,
                v && mdl.owner == 1 && s_ack_i, t && mdl.owner == 1};
    endfunction

    wire [70:0] obs = {s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_dat_o,
                       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o};

    task automatic drop_all();
        m0_cyc = 0; m0_stb = 0; m0_we = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0;
    endtask

    task automatic do_reset();
        @(negedge wb_clk);
        drop_all();
        stall = 0; force_ack = 0; rand_ack = 0; wb_rst = 1;
        @(negedge wb_clk);
        wb_rst = 0;
    endtask

    task automatic test_reset();
        wb_rst = 1; m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10;
        repeat (3) begin
            @(negedge wb_clk);
            tests_run++;
            if (obs !== 71'h0) begin
                tests_failed++;
                $display("FAIL reset_outputs: got %h want 0", obs);
            end
        end
        drop_all(); wb_rst = 0;
        @(negedge wb_clk);
        tests_run++;
        if (obs !== 71'h0) begin
            tests_failed++;
            $display("FAIL post_reset_idle: got %h want 0", obs);
        end
    endtask

    task automatic test_single_read();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_addr = 32'h10;
        #1;
        tests_run++;
        if ({s_cyc_o, s_stb_o} !== 2'b00) begin
            tests_failed++;
            $display("FAIL read_idle_no_strobe: got %b want 00", {s_cyc_o, s_stb_o});
        end
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, s_stb_o, s_addr_o, m0_ack_o} !== {2'b11, 32'h10, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_grant_c1: got %b %b %h %b want 1 1 10 0",
                     s_cyc_o, s_stb_o, s_addr_o, m0_ack_o);
        end
        @(negedge wb_clk);
        tests_run++;
        if ({m0_ack_o, m1_ack_o, m0_dat_o} !== {2'b10, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL read_ack_c2: got ack0=%b ack1=%b dat=%h want 1 0 deadbeef",
                     m0_ack_o, m1_ack_o, m0_dat_o);
        end
        drop_all();
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, m0_ack_o, m1_ack_o} !== 3'b000) begin
            tests_failed++;
            $display("FAIL read_release: got %b want 000", {s_cyc_o, m0_ack_o, m1_ack_o});
        end
    endtask

    task automatic test_tie_handover();
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h24;
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, s_addr_o} !== {1'b1, 32'h10}) begin
            tests_failed++;
            $display("FAIL tie_m0_first: got cyc=%b addr=%h want 1 10", s_cyc_o, s_addr_o);
        end
        @(negedge wb_clk);
        tests_run++;
        if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL tie_m0_ack: got %b want 10", {m0_ack_o, m1_ack_o});
        end
        m0_cyc = 0; m0_stb = 0;
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, s_addr_o} !== {1'b1, 32'h24}) begin
            tests_failed++;
            $display("FAIL tie_direct_handover: got cyc=%b addr=%h want 1 24", s_cyc_o, s_addr_o);
        end
        @(negedge wb_clk);
        tests_run++;
        if ({m0_ack_o, m1_ack_o} !== 2'b01) begin
            tests_failed++;
            $display("FAIL tie_m1_ack: got %b want 01", {m0_ack_o, m1_ack_o});
        end
        drop_all();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h14;
        m1_cyc = 1; m1_stb = 1; m1_addr = 32'h28;
        for (int cyc = 0; cyc < 80 && n < 8; cyc++) begin
            logic a0, a1;
            @(negedge wb_clk);
            a0 = m0_ack_o; a1 = m1_ack_o;
            if (a0 || a1) begin
                tests_run++;
                if ({a1, a0} !== ((n % 2 == 0) ? 2'b01 : 2'b10)) begin
                    tests_failed++;
                    $display("FAIL alternate_%0d: got ack1ack0=%b%b want master %0d",
                             n, a1, a0, n % 2);
                end
                n++;
            end
            m0_cyc = !a0; m0_stb = !a0;
            m1_cyc = !a1; m1_stb = !a1;
        end
        tests_run++;
        if (n != 8) begin
            tests_failed++;
            $display("FAIL alternate_count: got %0d transfers want 8", n);
        end
        drop_all();
    endtask

    task automatic test_timeout();
        do_reset();
        stall = 1;
        m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_addr = 32'h20; m1_dat = 32'h55;
        @(negedge wb_clk);
        tests_run++;
        if ({s_stb_o, s_we_o, s_addr_o, s_dat_o} !== {2'b11, 32'h20, 32'h55}) begin
            tests_failed++;
            $display("FAIL timeout_first_strobe: got %b %b %h %h want 1 1 20 55",
                     s_stb_o, s_we_o, s_addr_o, s_dat_o);
        end
        for (int k = 2; k <= 16; k++) begin
            @(negedge wb_clk);
            tests_run++;
            if ({m1_err_o, s_stb_o} !== 2'b01) begin
                tests_failed++;
                $display("FAIL timeout_wait_c%0d: got err=%b stb=%b want 0 1", k, m1_err_o, s_stb_o);
            end
        end
        @(negedge wb_clk);
        tests_run++;
        if ({m1_err_o, m1_ack_o, s_cyc_o, s_stb_o} !== 4'b1000) begin
            tests_failed++;
            $display("FAIL timeout_err_pulse: got err=%b ack=%b cyc=%b stb=%b want 1 0 0 0",
                     m1_err_o, m1_ack_o, s_cyc_o, s_stb_o);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge wb_clk);
            tests_run++;
            if ({m1_err_o, s_cyc_o} !== 2'b00) begin
                tests_failed++;
                $display("FAIL timeout_blocked_%0d: got err=%b cyc=%b want 0 0", k, m1_err_o, s_cyc_o);
            end
        end
        m1_cyc = 0; m1_stb = 0;
        @(negedge wb_clk);
        m1_cyc = 1; m1_stb = 1; stall = 0;
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, s_addr_o} !== {1'b1, 32'h20}) begin
            tests_failed++;
            $display("FAIL timeout_regrant: got cyc=%b addr=%h want 1 20", s_cyc_o, s_addr_o);
        end
        @(negedge wb_clk);
        tests_run++;
        if ({m1_ack_o, m1_err_o} !== 2'b10) begin
            tests_failed++;
            $display("FAIL timeout_regrant_ack: got ack=%b err=%b want 1 0", m1_ack_o, m1_err_o);
        end
        drop_all();
    endtask

    task automatic test_reset_abort();
        do_reset();
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_addr = 32'h24;
        @(negedge wb_clk);
        tests_run++;
        if (s_cyc_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL abort_m1_granted: got cyc=%b want 1", s_cyc_o);
        end
        wb_rst = 1;
        #1;
        tests_run++;
        if ({s_cyc_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL abort_in_reset: got %b want 00000",
                     {s_cyc_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 5'b0) begin
            tests_failed++;
            $display("FAIL abort_after_edge: got %b want 00000",
                     {s_cyc_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
        end
        wb_rst = 0; drop_all();
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10;
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, s_addr_o, m0_ack_o} !== {1'b1, 32'h10, 1'b0}) begin
            tests_failed++;
            $display("FAIL abort_m0_grant: got cyc=%b addr=%h ack=%b want 1 10 0",
                     s_cyc_o, s_addr_o, m0_ack_o);
        end
        @(negedge wb_clk);
        tests_run++;
        if ({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o} !== {4'b1000, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL abort_m0_ack: got %b%b%b%b dat=%h want 1000 deadbeef",
                     m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, m0_dat_o);
        end
        drop_all();
    endtask

    task automatic test_idle_ack();
        do_reset();
        force_ack = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge wb_clk);
            tests_run++;
            if ({m0_ack_o, m1_ack_o, s_cyc_o} !== 3'b000) begin
                tests_failed++;
                $display("FAIL idle_ack_ignored_%0d: got %b want 000", k, {m0_ack_o, m1_ack_o, s_cyc_o});
            end
        end
        force_ack = 0;
        m0_cyc = 1; m0_stb = 1; m0_addr = 32'h10;
        @(negedge wb_clk);
        tests_run++;
        if ({s_cyc_o, s_addr_o} !== {1'b1, 32'h10}) begin
            tests_failed++;
            $display("FAIL idle_ack_then_grant: got cyc=%b addr=%h want 1 10", s_cyc_o, s_addr_o);
        end
        @(negedge wb_clk);
        drop_all();
    endtask

    task automatic test_random();
        int flip;
        do_reset();
        rand_ack = 1;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            logic [70:0] exp_v;
            @(negedge wb_clk);
            exp_v = expect_outs();
            tests_run++;
            if (obs !== exp_v) begin
                tests_failed++;
                $display("FAIL random_c%0d: got %h want %h", cyc, obs, exp_v);
            end
            if (cyc % 60 == 0) stall = ($urandom_range(0, 2) == 0);
            flip      = stall ? 40 : 4;
            wb_rst    = ($urandom_range(0, 99) == 0);
            force_ack = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, flip) == 0) m0_cyc = !m0_cyc;
            if ($urandom_range(0, flip) == 0) m1_cyc = !m1_cyc;
            m0_stb  = m0_cyc && ($urandom_range(0, 3) != 0);
            m1_stb  = m1_cyc && ($urandom_range(0, 3) != 0);
            m0_we   = 1'($urandom);
            m1_we   = 1'($urandom);
            m0_addr = $urandom & 32'h0000_00FC;
            m1_addr = $urandom & 32'h0000_00FC;
            m0_dat  = $urandom;
            m1_dat  = $urandom;
        end
        wb_rst = 0; force_ack = 0; stall = 0; drop_all();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie_handover();
        test_back_to_back();
        test_timeout();
        test_reset_abort();
        test_idle_ack();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
